// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch/decode/execute sequencer and flag register for the 4-bit CPU.
// Define FETCH_TIMEOUT_EN to add the fetch watchdog and the sticky ERR state.
module fetch_sequencer #(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 8,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [3:0]         opcode,
    output logic [3:0]         imm,
    input  logic               jmp_sel,
    input  logic               reg_en,
    input  logic               alu_zf,
    input  logic               alu_sf,
    input  logic               alu_cf,
    output logic               zf,
    output logic               sf,
    output logic               cf,
    output logic               exec_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic               fetch_err
);

    // Opcode sits in the top nibble, so the word must hold at least opcode + immediate.
    if (TIMEOUT < 1 || INSTR_W < 8) begin : g_bad_param
        $error("fetch_sequencer: TIMEOUT must be >= 1 and INSTR_W >= 8");
    end

`ifdef FETCH_TIMEOUT_EN
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, ERR} state_t;
`else
    typedef enum logic [1:0] {IDLE, FETCH, DECODE, EXEC} state_t;
`endif

    state_t state;
    state_t state_nxt;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             timed_out;

    // Counts ack-less FETCH cycles; any other state clears it so each fetch starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == FETCH && !imem_ack) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    assign timed_out = (wait_cnt == CNT_W'(TIMEOUT - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        imem_req   = 1'b0;
        exec_valid = 1'b0;
        fetch_err  = 1'b0;
        case (state)
            IDLE: begin
                if (run) state_nxt = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_nxt = DECODE;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (timed_out) begin
                    state_nxt = ERR;
                end
`endif
            end
            DECODE: begin
                state_nxt = EXEC;
            end
            EXEC: begin
                exec_valid = 1'b1;
                state_nxt  = run ? FETCH : IDLE;
            end
`ifdef FETCH_TIMEOUT_EN
            ERR: begin
                fetch_err = 1'b1;
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign imem_addr = pc;

    // Instruction latch on accepted fetch; PC and flags retire on the EXEC exit edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= '0;
            opcode <= '0;
            imm    <= '0;
            zf     <= 1'b0;
            sf     <= 1'b0;
            cf     <= 1'b0;
        end else begin
            if (state == FETCH && imem_ack) begin
                opcode <= imem_data[INSTR_W-1 -: 4];
                imm    <= imem_data[3:0];
            end
            if (state == EXEC) begin
                pc <= jmp_sel ? ADDR_W'(imm) : pc + ADDR_W'(1);
                if (reg_en) begin
                    {zf, sf, cf} <= {alu_zf, alu_sf, alu_cf};
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: bench acting as instruction memory and control unit, with a
// transaction-level model of PC, flags and instruction timing.
module tb_fetch_sequencer;
    localparam int ADDR_W  = 4;
    localparam int INSTR_W = 8;
    localparam int TIMEOUT = 15;
    localparam int NPC     = 1 << ADDR_W;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               run;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_data;
    logic [3:0]         opcode;
    logic [3:0]         imm;
    logic               jmp_sel;
    logic               reg_en;
    logic               alu_zf;
    logic               alu_sf;
    logic               alu_cf;
    logic               zf;
    logic               sf;
    logic               cf;
    logic               exec_valid;
    logic [ADDR_W-1:0]  pc;
    logic               fetch_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem [NPC];
    int         m_pc;
    logic [2:0] m_flags;

    always #5 clk = ~clk;

    fetch_sequencer #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .opcode(opcode), .imm(imm), .jmp_sel(jmp_sel), .reg_en(reg_en),
        .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_cf(alu_cf),
        .zf(zf), .sf(sf), .cf(cf), .exec_valid(exec_valid), .pc(pc), .fetch_err(fetch_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic junk_ctrl;
        jmp_sel = 1'($urandom);
        reg_en  = 1'($urandom);
        {alu_zf, alu_sf, alu_cf} = 3'($urandom);
    endtask

    // Called one step after the edge that entered FETCH; returns one step after the EXEC exit edge.
    task automatic do_instr(input int wait_cyc, input bit jmp, input bit wr,
                            input bit [2:0] fl, input bit run_next);
        logic [7:0] word;
        check("fetch_req", 32'(imem_req), 1);
        check("fetch_addr", 32'(imem_addr), 32'(m_pc));
        for (int i = 0; i < wait_cyc; i++) begin
            imem_ack  = 1'b0;
            imem_data = 8'($urandom);
            junk_ctrl();
            tick();
            check("wait_req", 32'(imem_req), 1);
            check("wait_addr", 32'(imem_addr), 32'(m_pc));
            check("wait_valid", 32'(exec_valid), 0);
        end
        word      = mem[m_pc];
        imem_ack  = 1'b1;
        imem_data = word;
        tick();
        check("dec_req", 32'(imem_req), 0);
        check("dec_valid", 32'(exec_valid), 0);
        check("dec_opcode", 32'(opcode), 32'(word[7:4]));
        check("dec_imm", 32'(imm), 32'(word[3:0]));
        imem_ack  = 1'($urandom);
        imem_data = 8'($urandom);
        run       = 1'($urandom);
        junk_ctrl();
        tick();
        check("exec_valid", 32'(exec_valid), 1);
        check("exec_opcode", 32'(opcode), 32'(word[7:4]));
        check("exec_pc", 32'(pc), 32'(m_pc));
        check("exec_flags", 32'({zf, sf, cf}), 32'(m_flags));
        imem_ack = 1'b0;
        jmp_sel  = jmp;
        reg_en   = wr;
        {alu_zf, alu_sf, alu_cf} = fl;
        run      = run_next;
        tick();
        m_pc = jmp ? int'(word[3:0]) % NPC : (m_pc + 1) % NPC;
        if (wr) m_flags = fl;
        check("ret_valid", 32'(exec_valid), 0);
        check("ret_pc", 32'(pc), 32'(m_pc));
        check("ret_flags", 32'({zf, sf, cf}), 32'(m_flags));
        check("ret_req", 32'(imem_req), 32'(run_next));
        check("ret_err", 32'(fetch_err), 0);
        junk_ctrl();
    endtask

    // Sits in IDLE with stray acks that must be ignored, then restarts.
    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            imem_ack  = 1'($urandom);
            imem_data = 8'($urandom);
            run       = 1'b0;
            tick();
            check("idle_req", 32'(imem_req), 0);
            check("idle_valid", 32'(exec_valid), 0);
            check("idle_pc", 32'(pc), 32'(m_pc));
        end
        imem_ack = 1'b0;
        run      = 1'b1;
        tick();
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        #1;
        m_pc    = 0;
        m_flags = 3'b000;
        check("rst_req", 32'(imem_req), 0);
        check("rst_pc", 32'(pc), 0);
        check("rst_flags", 32'({zf, sf, cf}), 0);
        check("rst_valid", 32'(exec_valid), 0);
        check("rst_opcode", 32'({opcode, imm}), 0);
        check("rst_err", 32'(fetch_err), 0);
        for (int i = 0; i < 3; i++) begin
            imem_ack = 1'($urandom);
            tick();
            check("rst_hold_valid", 32'(exec_valid), 0);
            check("rst_hold_req", 32'(imem_req), 0);
        end
        imem_ack = 1'b0;
        rst_n    = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_data = '0;
        jmp_sel = 1'b0; reg_en = 1'b0; alu_zf = 1'b0; alu_sf = 1'b0; alu_cf = 1'b0;
        m_pc = 0; m_flags = 3'b000;
        for (int i = 0; i < NPC; i++) mem[i] = 8'($urandom);
        tick();
        tick();
        check("reset_req", 32'(imem_req), 0);
        check("reset_addr", 32'(imem_addr), 0);
        check("reset_pc", 32'(pc), 0);
        check("reset_regs", 32'({opcode, imm, zf, sf, cf, exec_valid, fetch_err}), 0);
        rst_n = 1'b1;
        tick();
        check("idle_no_run", 32'(imem_req), 0);

        mem[0] = 8'h41; mem[1] = 8'h25; mem[2] = 8'h3A;
        mem[10] = 8'h9F; mem[15] = 8'h10; mem[3] = 8'h73;
        run = 1'b1;
        tick();
        do_instr(0, 1'b0, 1'b1, 3'b100, 1'b1);   // 0 -> 1, zf=1
        do_instr(0, 1'b0, 1'b1, 3'b000, 1'b1);   // 1 -> 2, flags cleared
        do_instr(0, 1'b1, 1'b0, 3'b111, 1'b1);   // 2 jumps to A
        do_instr(1, 1'b1, 1'b0, 3'b010, 1'b1);   // A jumps to F
        do_instr(4, 1'b0, 1'b1, 3'b011, 1'b1);   // F wraps to 0, slow ack
        do_instr(0, 1'b0, 1'b0, 3'b101, 1'b1);   // 0 -> 1
        do_instr(2, 1'b0, 1'b0, 3'b101, 1'b1);   // 1 -> 2
        do_instr(0, 1'b0, 1'b1, 3'b001, 1'b1);   // 2 falls through to 3
        do_instr(0, 1'b1, 1'b0, 3'b000, 1'b1);   // 3 jumps to itself
        do_instr(TIMEOUT - 1, 1'b0, 1'b1, 3'b110, 1'b0);
        idle_gap(3);

        for (int i = 0; i < NPC; i++) mem[i] = 8'($urandom);
        for (int n = 0; n < 150; n++) begin
            bit rn;
            rn = ($urandom_range(0, 4) != 0);
            do_instr($urandom_range(0, 4), 1'($urandom), 1'($urandom), 3'($urandom), rn);
            if (!rn) idle_gap($urandom_range(0, 3));
        end

        // Abort an instruction in the middle of its fetch.
        imem_ack = 1'b0;
        tick();
        tick();
        check("mid_fetch_req", 32'(imem_req), 1);
        apply_reset();
        run = 1'b1;
        tick();
        do_instr(0, 1'b0, 1'b1, 3'b010, 1'b1);

        // Memory that never answers.
        imem_ack = 1'b0;
        for (int i = 1; i < TIMEOUT; i++) begin
            tick();
            check("to_wait_req", 32'(imem_req), 1);
            check("to_wait_err", 32'(fetch_err), 0);
        end
        tick();
`ifdef FETCH_TIMEOUT_EN
        check("to_err", 32'(fetch_err), 1);
        check("to_req", 32'(imem_req), 0);
        check("to_pc", 32'(pc), 32'(m_pc));
        for (int i = 0; i < 4; i++) begin
            imem_ack = 1'b1;
            tick();
            check("err_hold", 32'(fetch_err), 1);
            check("err_req", 32'(imem_req), 0);
            check("err_valid", 32'(exec_valid), 0);
        end
`else
        for (int i = 0; i < 5; i++) tick();
        check("nto_req", 32'(imem_req), 1);
        check("nto_err", 32'(fetch_err), 0);
        check("nto_addr", 32'(imem_addr), 32'(m_pc));
`endif
        apply_reset();
        check("final_err", 32'(fetch_err), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
